// File: rtl/gtp_link_pkg.sv
// Shared framing definitions for the GTP link: header layout, sync word and
// deframer/framer state encoding.
package gtp_link_pkg;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;
    localparam int          CNT_W_DEFAULT     = 16;

    // Header word layout: {sync[15:0], type[7:0], len[7:0]}
    localparam int SYNC_HI = 31;
    localparam int SYNC_LO = 16;
    localparam int TYPE_HI = 15;
    localparam int TYPE_LO = 8;
    localparam int LEN_HI  = 7;
    localparam int LEN_LO  = 0;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CSUM,
        ABORT
    } link_state_t;

endpackage

// File: rtl/gtp_rx_deframer.sv
// Recovers header-delimited frames from the RX FIFO word stream, strips header
// and checksum, flags bad or aborted frames on the last beat, counts events.
module gtp_rx_deframer
    import gtp_link_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT,
    parameter int          TIMEOUT   = 1024,
    parameter int          CNT_W     = CNT_W_DEFAULT
) (
    input  logic             core_clk,
    input  logic             core_rst_n,
    input  logic [31:0]      s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    output logic [31:0]      m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             m_tuser,
    output logic [7:0]       m_ttype,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] csum_err_cnt,
    output logic [CNT_W-1:0] sync_err_cnt,
    output logic [CNT_W-1:0] abort_cnt,
    output logic             busy
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    link_state_t      state;
    logic [7:0]       remaining;
    logic [31:0]      acc;
    logic [31:0]      hold;
    logic             hold_v;
    logic [TMO_W-1:0] tmo;

    logic out_free;
    logic accept;
    logic idle;
    logic tmo_expire;
    logic hdr_ok;
    logic csum_ok;

    // Framing is taken from the header length only.
    logic unused_tlast;
    assign unused_tlast = s_tlast;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // NOTE: every always_comb output gets a value on every path, so no latches.
    always_comb begin
        out_free   = !m_tvalid || m_tready;
        s_tready   = (state == HUNT) || ((state != ABORT) && out_free);
        accept     = s_tvalid && s_tready;
        idle       = s_tready && !s_tvalid;
        tmo_expire = idle && (tmo == TMO_W'(TIMEOUT - 1))
                     && ((state == PAYLOAD) || (state == CSUM));
        hdr_ok     = (s_tdata[SYNC_HI:SYNC_LO] == SYNC_WORD)
                     && (s_tdata[LEN_HI:LEN_LO] != 8'd0);
        csum_ok    = (s_tdata == acc);
        busy       = (state != HUNT);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read
    // in this block sees the value from before the clock edge.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state        <= HUNT;
            remaining    <= 8'd0;
            acc          <= 32'd0;
            hold         <= 32'd0;
            hold_v       <= 1'b0;
            tmo          <= '0;
            m_tdata      <= 32'd0;
            m_tvalid     <= 1'b0;
            m_tlast      <= 1'b0;
            m_tuser      <= 1'b0;
            m_ttype      <= 8'd0;
            frame_cnt    <= '0;
            csum_err_cnt <= '0;
            sync_err_cnt <= '0;
            abort_cnt    <= '0;
        end else begin
            // Drain first; a load later in this block overrides it.
            if (m_tvalid && m_tready) m_tvalid <= 1'b0;

            unique case (state)
                HUNT: begin
                    if (accept) begin
                        if (hdr_ok) begin
                            m_ttype   <= s_tdata[TYPE_HI:TYPE_LO];
                            remaining <= s_tdata[LEN_HI:LEN_LO];
                            acc       <= s_tdata;
                            tmo       <= '0;
                            state     <= PAYLOAD;
                        end else begin
                            sync_err_cnt <= sat_inc(sync_err_cnt);
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        acc       <= acc + s_tdata;
                        remaining <= remaining - 8'd1;
                        tmo       <= '0;
                        if (hold_v) begin
                            m_tdata  <= hold;
                            m_tvalid <= 1'b1;
                            m_tlast  <= 1'b0;
                            m_tuser  <= 1'b0;
                        end
                        hold   <= s_tdata;
                        hold_v <= 1'b1;
                        if (remaining == 8'd1) state <= CSUM;
                    end else if (tmo_expire) begin
                        if (hold_v) begin
                            state <= ABORT;
                        end else begin
                            abort_cnt <= sat_inc(abort_cnt);
                            state     <= HUNT;
                        end
                    end else if (idle) begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                CSUM: begin
                    if (accept) begin
                        m_tdata  <= hold;
                        m_tvalid <= 1'b1;
                        m_tlast  <= 1'b1;
                        m_tuser  <= !csum_ok;
                        hold_v   <= 1'b0;
                        tmo      <= '0;
                        if (csum_ok) frame_cnt    <= sat_inc(frame_cnt);
                        else         csum_err_cnt <= sat_inc(csum_err_cnt);
                        state <= HUNT;
                    end else if (tmo_expire) begin
                        state <= ABORT;
                    end else if (idle) begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                ABORT: begin
                    // Only reached with a held word; flush it as a flagged last beat.
                    if (out_free) begin
                        m_tdata   <= hold;
                        m_tvalid  <= 1'b1;
                        m_tlast   <= 1'b1;
                        m_tuser   <= 1'b1;
                        hold_v    <= 1'b0;
                        abort_cnt <= sat_inc(abort_cnt);
                        state     <= HUNT;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_gtp_rx_deframer.sv
// Self-checking bench for gtp_rx_deframer: directed frames plus randomized
// frames compared against a frame-level model of payload, flags and counters.
module tb_gtp_rx_deframer;
    import gtp_link_pkg::*;

    localparam int TMO = 32;
    localparam int CW  = 4;
    localparam logic [CW-1:0] SAT = '1;

    typedef logic [33:0] beat_t;  // {tlast, tuser, tdata}

    logic          core_clk;
    logic          core_rst_n;
    logic [31:0]   s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [31:0]   m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          m_tuser;
    logic [7:0]    m_ttype;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] csum_err_cnt;
    logic [CW-1:0] sync_err_cnt;
    logic [CW-1:0] abort_cnt;
    logic          busy;

    int    n_assert = 0;
    int    n_fail   = 0;
    bit    stuck;
    bit    rand_ready;
    beat_t got[$];
    beat_t exp_q[$];
    logic [31:0] tx_q[$];

    gtp_rx_deframer #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .core_clk     (core_clk),
        .core_rst_n   (core_rst_n),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tlast      (s_tlast),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .m_tuser      (m_tuser),
        .m_ttype      (m_ttype),
        .frame_cnt    (frame_cnt),
        .csum_err_cnt (csum_err_cnt),
        .sync_err_cnt (sync_err_cnt),
        .abort_cnt    (abort_cnt),
        .busy         (busy)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    // Inputs change 1 time unit after posedge, so a handshake seen at negedge
    // is the one that completes on the following posedge.
    always @(negedge core_clk)
        if (m_tvalid && m_tready) got.push_back({m_tlast, m_tuser, m_tdata});

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge core_clk);
        #1;
        if (rand_ready) m_tready = ($urandom_range(0, 9) < 6);
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        bit acc;
        int n;
        s_tvalid = 1'b0;
        repeat (gap) tick();
        s_tdata  = w;
        s_tlast  = 1'($urandom_range(0, 1));
        s_tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge core_clk);
            acc = s_tready;
            tick();
            n++;
        end while (!acc && n < 4000);
        if (!acc) stuck = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = $urandom;
    endtask

    task automatic send_all(input int gap_max);
        while (tx_q.size() > 0) send(tx_q.pop_front(), $urandom_range(0, gap_max));
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        repeat (3) tick();
    endtask

    // Reference model: a frame is header, payload, checksum; the output is the
    // payload with tlast on the final word and tuser set when the sum mismatches.
    task automatic build_frame(input logic [7:0] ftype, input int len, input bit bad);
        logic [31:0] hdr, sum, w;
        hdr = {SYNC_WORD_DEFAULT, ftype, 8'(len)};
        sum = hdr;
        tx_q.push_back(hdr);
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            sum = sum + w;
            tx_q.push_back(w);
            exp_q.push_back({(i == len - 1), (i == len - 1) && bad, w});
        end
        tx_q.push_back(bad ? (sum ^ (32'h1 << $urandom_range(0, 31))) : sum);
    endtask

    task automatic do_reset();
        core_rst_n = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = 32'd0;
        s_tlast    = 1'b0;
        m_tready   = 1'b1;
        rand_ready = 1'b0;
        repeat (2) tick();
        core_rst_n = 1'b1;
        tick();
        got.delete();
        exp_q.delete();
        tx_q.delete();
        stuck = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_assert++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_out: got %h expected 0", {m_tvalid, m_tlast, m_tuser, m_tdata});
        end
        n_assert++;
        if ({frame_cnt, csum_err_cnt, sync_err_cnt, abort_cnt, m_ttype} !== '0) begin
            n_fail++;
            $display("FAIL reset_status: got %h expected 0",
                     {frame_cnt, csum_err_cnt, sync_err_cnt, abort_cnt, m_ttype});
        end
        n_assert++;
        if ({busy, s_tready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_busy_ready: got %b expected 01", {busy, s_tready});
        end
    endtask

    task automatic test_good_frame();
        do_reset();
        tx_q  = '{32'hA55A0103, 32'h11, 32'h22, 32'h33, 32'hA55A0169};
        exp_q = '{{2'b00, 32'h11}, {2'b00, 32'h22}, {2'b10, 32'h33}};
        send_all(0);
        wait_beats(exp_q.size(), 50);
        n_assert++;
        if (got.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL good_count: got %0d expected %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_assert++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL good_beat%0d: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 34'bx, exp_q[i]);
            end
        end
        n_assert++;
        if ({m_ttype, frame_cnt, csum_err_cnt, busy} !== {8'h01, CW'(1), CW'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL good_status: got type %h frame %0d csum %0d busy %b expected 01 1 0 0",
                     m_ttype, frame_cnt, csum_err_cnt, busy);
        end
    endtask

    task automatic test_bad_csum();
        do_reset();
        tx_q  = '{32'hA55A0103, 32'h11, 32'h22, 32'h33, 32'h00000000};
        exp_q = '{{2'b00, 32'h11}, {2'b00, 32'h22}, {2'b11, 32'h33}};
        send_all(0);
        wait_beats(exp_q.size(), 50);
        n_assert++;
        if (got.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL badcs_count: got %0d expected %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_assert++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL badcs_beat%0d: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 34'bx, exp_q[i]);
            end
        end
        n_assert++;
        if ({frame_cnt, csum_err_cnt} !== {CW'(0), CW'(1)}) begin
            n_fail++;
            $display("FAIL badcs_counters: got frame %0d csum %0d expected 0 1", frame_cnt, csum_err_cnt);
        end
    endtask

    task automatic test_sync_errors();
        do_reset();
        tx_q  = '{32'hDEADBEEF, 32'hA55A0000, 32'hA55A0103, 32'h11, 32'h22, 32'h33, 32'hA55A0169};
        exp_q = '{{2'b00, 32'h11}, {2'b00, 32'h22}, {2'b10, 32'h33}};
        send_all(1);
        wait_beats(exp_q.size(), 50);
        n_assert++;
        if (got.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL sync_count: got %0d expected %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_assert++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL sync_beat%0d: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 34'bx, exp_q[i]);
            end
        end
        n_assert++;
        if ({sync_err_cnt, frame_cnt} !== {CW'(2), CW'(1)}) begin
            n_fail++;
            $display("FAIL sync_counters: got sync %0d frame %0d expected 2 1", sync_err_cnt, frame_cnt);
        end
    endtask

    task automatic test_random_frames();
        int n_good = 0, n_bad = 0, n_junk = 0;
        logic [7:0]  ftype;
        logic [31:0] junk;
        bit bad;
        do_reset();
        for (int f = 0; f < 8; f++) begin
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                junk = $urandom;
                if (junk[31:16] == SYNC_WORD_DEFAULT) junk[31:16] = 16'h1234;
                tx_q.push_back(junk);
                n_junk++;
            end
            ftype = 8'($urandom);
            bad   = ($urandom_range(0, 2) == 0);
            build_frame(ftype, $urandom_range(1, 16), bad);
            if (bad) n_bad++;
            else     n_good++;
        end
        rand_ready = 1'b1;
        send_all(3);
        rand_ready = 1'b0;
        m_tready   = 1'b1;
        wait_beats(exp_q.size(), 300);
        n_assert++;
        if (got.size() != exp_q.size() || stuck) begin
            n_fail++;
            $display("FAIL rand_count: got %0d expected %0d (stuck %b)", got.size(), exp_q.size(), stuck);
        end
        foreach (exp_q[i]) begin
            n_assert++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_beat%0d: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 34'bx, exp_q[i]);
            end
        end
        n_assert++;
        if ({frame_cnt, csum_err_cnt, sync_err_cnt, m_ttype} !==
            {CW'((n_good > 15) ? 15 : n_good), CW'((n_bad > 15) ? 15 : n_bad),
             CW'((n_junk > 15) ? 15 : n_junk), ftype}) begin
            n_fail++;
            $display("FAIL rand_status: got %0d %0d %0d %h expected %0d %0d %0d %h",
                     frame_cnt, csum_err_cnt, sync_err_cnt, m_ttype, n_good, n_bad, n_junk, ftype);
        end
    endtask

    task automatic test_long_frame();
        bit done = 1'b0;
        do_reset();
        build_frame(8'h7E, 255, 1'b0);
        rand_ready = 1'b1;
        fork
            begin
                send_all(TMO - 1);
                rand_ready = 1'b0;
                m_tready   = 1'b1;
                wait_beats(exp_q.size(), 100);
                done = 1'b1;
            end
            begin
                beat_t prev;
                bit    stalled = 1'b0;
                while (!done) begin
                    @(negedge core_clk);
                    if (stalled) begin
                        n_assert++;
                        if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== {1'b1, prev}) begin
                            n_fail++;
                            $display("FAIL long_stall_stable: got %b %h expected 1 %h",
                                     m_tvalid, {m_tlast, m_tuser, m_tdata}, prev);
                        end
                    end
                    if (m_tvalid && !m_tready && busy) begin
                        n_assert++;
                        if (s_tready !== 1'b0) begin
                            n_fail++;
                            $display("FAIL long_backpressure: got s_tready %b expected 0", s_tready);
                        end
                    end
                    stalled = m_tvalid && !m_tready;
                    prev    = {m_tlast, m_tuser, m_tdata};
                end
            end
        join
        n_assert++;
        if (got.size() != 255 || stuck) begin
            n_fail++;
            $display("FAIL long_count: got %0d expected 255 (stuck %b)", got.size(), stuck);
        end
        foreach (exp_q[i]) begin
            n_assert++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL long_beat%0d: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 34'bx, exp_q[i]);
            end
        end
        n_assert++;
        if ({frame_cnt, abort_cnt} !== {CW'(1), CW'(0)}) begin
            n_fail++;
            $display("FAIL long_counters: got frame %0d abort %0d expected 1 0", frame_cnt, abort_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send(32'hA55A0204, 0);
        send(32'h0000000A, 0);
        send(32'h0000000B, 0);
        repeat (TMO - 1) tick();
        n_assert++;
        if ({busy, got.size() == 1} !== 2'b11) begin
            n_fail++;
            $display("FAIL tmo_early: got busy %b beats %0d expected 1 1", busy, got.size());
        end
        wait_beats(2, TMO + 10);
        exp_q = '{{2'b00, 32'hA}, {2'b11, 32'hB}};
        n_assert++;
        if (got.size() != 2) begin
            n_fail++;
            $display("FAIL tmo_count: got %0d expected 2", got.size());
        end
        foreach (exp_q[i]) begin
            n_assert++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL tmo_beat%0d: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 34'bx, exp_q[i]);
            end
        end
        n_assert++;
        if ({abort_cnt, busy} !== {CW'(1), 1'b0}) begin
            n_fail++;
            $display("FAIL tmo_abort1: got abort %0d busy %b expected 1 0", abort_cnt, busy);
        end
        // Header then silence: aborted with nothing emitted.
        send(32'hA55A0105, 0);
        repeat (TMO + 5) tick();
        n_assert++;
        if ({abort_cnt, busy, got.size() == 2} !== {CW'(2), 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL tmo_hdr_only: got abort %0d busy %b beats %0d expected 2 0 2",
                     abort_cnt, busy, got.size());
        end
        // A word accepted on the expiry cycle keeps the frame alive.
        send(32'hA55A0301, 0);
        send(32'h00000005, TMO - 1);
        send(32'hA55A0306, TMO - 1);
        wait_beats(3, 20);
        n_assert++;
        if (got.size() != 3 || got[got.size() - 1] !== {2'b10, 32'h5}) begin
            n_fail++;
            $display("FAIL tmo_expiry_accept: got %0d beats last %h expected 3 %h",
                     got.size(), got[got.size() - 1], {2'b10, 32'h5});
        end
        n_assert++;
        if ({frame_cnt, abort_cnt, m_ttype} !== {CW'(1), CW'(2), 8'h03}) begin
            n_fail++;
            $display("FAIL tmo_final: got frame %0d abort %0d type %h expected 1 2 03",
                     frame_cnt, abort_cnt, m_ttype);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        send(32'hA55A0103, 0);
        send(32'h00000011, 0);
        send(32'h00000022, 0);
        n_assert++;
        if ({busy, m_tvalid} !== 2'b11) begin
            n_fail++;
            $display("FAIL rstmid_pre: got busy %b valid %b expected 1 1", busy, m_tvalid);
        end
        core_rst_n = 1'b0;
        #1;
        n_assert++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata, m_ttype, busy} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h expected 0",
                     {m_tvalid, m_tlast, m_tuser, m_tdata, m_ttype, busy});
        end
        repeat (2) tick();
        core_rst_n = 1'b1;
        tick();
        tx_q  = '{32'hA55A0103, 32'h11, 32'h22, 32'h33, 32'hA55A0169};
        exp_q = '{{2'b00, 32'h11}, {2'b00, 32'h22}, {2'b10, 32'h33}};
        send_all(0);
        wait_beats(exp_q.size(), 50);
        n_assert++;
        if (got.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rstmid_count: got %0d expected %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_assert++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rstmid_beat%0d: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 34'bx, exp_q[i]);
            end
        end
        n_assert++;
        if ({frame_cnt, abort_cnt} !== {CW'(1), CW'(0)}) begin
            n_fail++;
            $display("FAIL rstmid_counters: got frame %0d abort %0d expected 1 0", frame_cnt, abort_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] junk;
        do_reset();
        for (int j = 0; j < 20; j++) begin
            junk = $urandom;
            if (junk[31:16] == SYNC_WORD_DEFAULT) junk[31:16] = 16'h0F0F;
            tx_q.push_back(junk);
        end
        send_all(0);
        tick();
        n_assert++;
        if (sync_err_cnt !== SAT) begin
            n_fail++;
            $display("FAIL sat_sync: got %0d expected %0d", sync_err_cnt, SAT);
        end
    endtask

    initial begin
        core_rst_n = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = 32'd0;
        s_tlast    = 1'b0;
        m_tready   = 1'b1;
        rand_ready = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_sync_errors();
        test_random_frames();
        test_long_frame();
        test_timeout();
        test_reset_mid_frame();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gtp_rx_deframer.md
Name: gtp_rx_deframer

Overview:
- Sits in the core_clk domain directly downstream of the GTP subsystem's RX FIFO output (gt2port_* AXI-Stream, 32-bit).
- Finds frame boundaries in the raw word stream, strips the header and checksum, and verifies a 32-bit additive checksum.
- Delivers the payload as an AXI-Stream with tlast and an error flag (tuser) on the final beat.
- Keeps saturating status counters for the loadboard control logic.

Parameters:
SYNC_WORD, 16'hA55A, value required in header bits [31:16]
TIMEOUT, 1024, idle input cycles allowed mid-frame before abort (>=2)
CNT_W, 16, width of status counters

Ports:
core_clk  in  1  sole clock
core_rst_n  in  1  asynchronous, active-low reset
s_tdata  in  32  word from RX FIFO (gt2port_tdata)
s_tvalid  in  1  input valid
s_tready  out  1  input ready
s_tlast  in  1  ignored; framing comes from the header only
m_tdata  out  32  payload word
m_tvalid  out  1  output valid (registered)
m_tready  in  1  downstream ready
m_tlast  out  1  last payload beat of frame
m_tuser  out  1  on the tlast beat: 1 = checksum error or abort
m_ttype  out  8  type field of the current frame; held until the next header
frame_cnt  out  CNT_W  frames delivered with good checksum
csum_err_cnt  out  CNT_W  frames with bad checksum
sync_err_cnt  out  CNT_W  words discarded while hunting (bad sync or len==0)
abort_cnt  out  CNT_W  frames ended by timeout
busy  out  1  state != HUNT

Behaviour:
- Reset (async assert, sync release): all outputs and counters 0, state HUNT, hold_v=0, checksum accumulator 0.
- Frame format: header {SYNC_WORD[15:0], type[7:0], len[7:0]}, then len payload words (1..255), then a checksum word.
  - Checksum = (header + all payload words) mod 2^32.
- s_tready = (state==HUNT) || !m_tvalid || m_tready.
- An accept is s_tvalid && s_tready.
- HUNT:
  - Accepted word with [31:16]==SYNC_WORD and len!=0: latch type into m_ttype, remaining=len, acc=word; go to PAYLOAD.
  - Any other accepted word: discard it, sync_err_cnt++.
- PAYLOAD:
  - Each accepted word: acc+=word, remaining--.
  - If hold_v, move hold into the output register with tlast=0, tuser=0.
  - Then hold<=word, hold_v=1.
  - When remaining reaches 0, go to CSUM.
- CSUM:
  - Accepted word: move hold to output with tlast=1, tuser=(word!=acc).
  - hold_v=0.
  - frame_cnt++ if match, else csum_err_cnt++.
  - Go to HUNT.
- Latency: payload word n appears on m_tdata the cycle after word n+1 (or the checksum) is accepted. The checksum is never output.
- Output register:
  - m_tvalid set on load.
  - Cleared when m_tvalid&&m_tready and nothing new is loaded the same cycle.
  - Load and drain in the same cycle is allowed (full throughput, 1 word/cycle).
  - m_tdata/tlast/tuser stable while m_tvalid && !m_tready.
- Timeout:
  - In PAYLOAD/CSUM, tmo counter increments on cycles with s_tready && !s_tvalid.
  - Cleared on every accept and on entry to PAYLOAD.
  - Backpressure cycles do not count.
  - When tmo==TIMEOUT-1, go to ABORT.
- ABORT:
  - s_tready=0.
  - If hold_v: wait for a free output, then emit hold with tlast=1, tuser=1.
  - abort_cnt++, go to HUNT.
  - If !hold_v (timeout before the first payload word): abort_cnt++ and go to HUNT immediately, nothing emitted.
- Counters saturate at all-ones; no wrap.
- Simultaneous events: an accept on the expiry cycle wins; tmo clears and there is no abort.
- Reset mid-frame discards the partial frame with no tlast emitted.

Decomposition:
- Package gtp_link_pkg holds:
  - SYNC_WORD default
  - header field bit positions (SYNC_HI=31, SYNC_LO=16, TYPE 15:8, LEN 7:0)
  - state enum {HUNT, PAYLOAD, CSUM, ABORT}
  - CNT_W default
- The TX framer will reuse this package.
- Single module; no sub-module. The saturating counter is a local function/generate, not a separate module.

Test Plan:
- Good frame, m_tready=1: 0xA55A0103, 0x11, 0x22, 0x33, 0xA55A0169.
  -> m_tdata 0x11, 0x22, 0x33; tlast only on 0x33; tuser=0; m_ttype=0x01; frame_cnt=1.
- Same frame with checksum 0x00000000.
  -> three beats; tlast+tuser=1 on 0x33; csum_err_cnt=1; frame_cnt=0.
- 0xDEADBEEF, 0xA55A0000, then the good frame.
  -> sync_err_cnt=2; good frame delivered intact; frame_cnt=1.
- 255-word frame with m_tready toggled pseudo-randomly and s_tvalid gaps < TIMEOUT.
  -> all 255 words in order, no drops or duplicates.
  -> s_tready=0 whenever m_tvalid && !m_tready outside HUNT.
  -> output stable while stalled.
- Header 0xA55A0204, payload 0xA, 0xB, then s_tvalid=0 for TIMEOUT cycles.
  -> beats 0xA (tlast=0), 0xB (tlast=1, tuser=1); abort_cnt=1; next good frame OK.
- core_rst_n pulsed low after 2 payload words.
  -> all outputs/counters 0 asynchronously; busy=0; a following good frame is delivered correctly.
